// File: rtl/instr_prefetch_mem_if.sv
// Control, program-load and fetch-stream signals of instr_prefetch_mem.
// The slave modport is the memory; the master modport is the control unit / fetch stage.
interface instr_prefetch_mem_if #(
  parameter int WORD_SIZE  = 19,
  parameter int ADDR_WIDTH = 8
);
  logic                  fetch_start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   fetch_len;
  logic                  flush;
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [WORD_SIZE-1:0]  load_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [WORD_SIZE-1:0]  instr_data;
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic                  busy;
  logic                  instr_parity_err;

  modport master (
    output fetch_start, start_addr, fetch_len, flush,
    output load_en, load_addr, load_data, instr_ready,
    input  instr_valid, instr_data, instr_addr, busy, instr_parity_err
  );

  modport slave (
    input  fetch_start, start_addr, fetch_len, flush,
    input  load_en, load_addr, load_data, instr_ready,
    output instr_valid, instr_data, instr_addr, busy, instr_parity_err
  );
endinterface

// File: rtl/instr_prefetch_mem.sv
// Instruction memory streaming sequential bursts through a fixed-latency read pipe into a prefetch FIFO.
// Define INSTR_PARITY_EN to store an even-parity bit per word and flag mismatches on the FIFO head.
module instr_prefetch_mem #(
  parameter int WORD_SIZE    = 19,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input logic                clk,
  input logic                rst_n,
  instr_prefetch_mem_if.slave bus
);

`ifdef INSTR_PARITY_EN
  localparam int MEM_W = WORD_SIZE + 1;
`else
  localparam int MEM_W = WORD_SIZE;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W:0] CREDIT_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [MEM_W-1:0]      mem       [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] pc;
  logic [LEN_W-1:0]      remaining;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [MEM_W-1:0]      pipe_data [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_addr [READ_LATENCY];
  logic [MEM_W-1:0]      fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_count, inflight;
  logic                  fifo_empty, push, pop, issue, busy, start_ok;
  logic [MEM_W-1:0]      load_word;

`ifdef INSTR_PARITY_EN
  assign load_word = {^bus.load_data, bus.load_data};
`else
  assign load_word = bus.load_data;
`endif

  assign fifo_empty = (fifo_count == '0);
  assign push       = pipe_vld[READ_LATENCY-1];
  assign pop        = !fifo_empty && bus.instr_ready && !bus.flush;
  assign start_ok   = (state == IDLE) && (state_nxt == FETCH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.fetch_start && bus.fetch_len != '0) state_nxt = FETCH;
        FETCH:   if (issue && remaining == LEN_W'(1)) state_nxt = DRAIN;
        DRAIN:   if (inflight == '0 && fifo_empty) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Credit counts both buffered and in-flight words, so the FIFO can never overflow.
  always_comb begin
    busy  = (state != IDLE);
    issue = (state == FETCH) && !bus.flush &&
            (({1'b0, fifo_count} + {1'b0, inflight}) < CREDIT_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      remaining  <= '0;
      pipe_vld   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else if (bus.flush) begin
      pipe_vld   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
    end else begin
      if (start_ok) begin
        pc        <= bus.start_addr;
        remaining <= bus.fetch_len;
      end else if (issue) begin
        pc        <= pc + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_W'(1);
      end
      for (int i = READ_LATENCY - 1; i > 0; i--) pipe_vld[i] <= pipe_vld[i-1];
      pipe_vld[0] <= issue;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      inflight   <= inflight + CNT_W'(issue) - CNT_W'(push);
    end
  end

  // NOTE: storage arrays carry no reset; the reset valid bits and pointers make their contents don't-care.
  // A read issued alongside a load to the same address sees the old word.
  always_ff @(posedge clk) begin
    if (bus.load_en) mem[bus.load_addr] <= load_word;
    if (issue) begin
      pipe_data[0] <= mem[pc];
      pipe_addr[0] <= pc;
    end
    for (int i = READ_LATENCY - 1; i > 0; i--) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
    end
    if (push) begin
      fifo_data[wr_ptr] <= pipe_data[READ_LATENCY-1];
      fifo_addr[wr_ptr] <= pipe_addr[READ_LATENCY-1];
    end
  end

  assign bus.busy        = busy;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr_data  = fifo_empty ? '0 : fifo_data[rd_ptr][WORD_SIZE-1:0];
  assign bus.instr_addr  = fifo_empty ? '0 : fifo_addr[rd_ptr];

`ifdef INSTR_PARITY_EN
  assign bus.instr_parity_err = !fifo_empty &&
      ((^fifo_data[rd_ptr][WORD_SIZE-1:0]) != fifo_data[rd_ptr][WORD_SIZE]);
`else
  assign bus.instr_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_prefetch_mem.sv
// Self-checking bench for instr_prefetch_mem: directed test-plan steps plus random bursts
// scored against a queue of expected {addr, data} words built from a reference memory image.
module tb_instr_prefetch_mem;
  localparam int WS = 19;
  localparam int AW = 8;
  localparam int RL = 2;
  localparam int FD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instr_prefetch_mem_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) ifc ();

  instr_prefetch_mem #(
    .WORD_SIZE(WS), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WS-1:0] data;
  } word_t;

  logic [WS-1:0] ref_mem [2**AW];
`ifdef INSTR_PARITY_EN
  bit            bad     [2**AW];
`endif
  word_t         exp_q   [$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: score a pop if it will happen at the coming edge, then advance to the next negedge.
  task automatic tick();
    word_t w;
    logic  exp_err;
    if (ifc.instr_valid && ifc.instr_ready && !ifc.flush) begin
      if (exp_q.size() == 0) begin
        check("extra_word_valid", ifc.instr_valid, 1'b0);
      end else begin
        w       = exp_q.pop_front();
        exp_err = 1'b0;
`ifdef INSTR_PARITY_EN
        exp_err = bad[w.addr];
`endif
        check("pop_addr", ifc.instr_addr, w.addr);
        check("pop_data", ifc.instr_data, w.data);
        check("pop_parity_err", ifc.instr_parity_err, exp_err);
      end
    end
    if (ifc.flush) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_word(input int addr, input logic [WS-1:0] data);
    ifc.load_en   = 1'b1;
    ifc.load_addr = AW'(addr);
    ifc.load_data = data;
    ref_mem[AW'(addr)] = data;
    tick();
    ifc.load_en = 1'b0;
  endtask

  task automatic start_burst(input int addr, input int len);
    ifc.fetch_start = 1'b1;
    ifc.start_addr  = AW'(addr);
    ifc.fetch_len   = (AW + 1)'(len);
    for (int i = 0; i < len; i++)
      exp_q.push_back('{addr: AW'(addr + i), data: ref_mem[AW'(addr + i)]});
    tick();
    ifc.fetch_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!ifc.instr_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, ifc.instr_valid, 1'b1);
  endtask

  // Run until every expected word is delivered and busy drops, then watch for stray words.
  task automatic wait_done(input string tag, input bit rnd_ready);
    int n = 0;
    while ((exp_q.size() != 0 || ifc.busy) && n < 300) begin
      if (rnd_ready) ifc.instr_ready = ($urandom_range(3) != 0);
      tick();
      n++;
    end
    ifc.instr_ready = 1'b1;
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_busy"}, ifc.busy, 1'b0);
    repeat (4) tick();
    check({tag, "_no_stray"}, ifc.instr_valid, 1'b0);
  endtask

  initial begin
    ifc.fetch_start = 1'b0;
    ifc.start_addr  = '0;
    ifc.fetch_len   = '0;
    ifc.flush       = 1'b0;
    ifc.load_en     = 1'b0;
    ifc.load_addr   = '0;
    ifc.load_data   = '0;
    ifc.instr_ready = 1'b1;
`ifdef INSTR_PARITY_EN
    for (int a = 0; a < 2**AW; a++) bad[a] = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", ifc.instr_valid, 1'b0);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_data", ifc.instr_data, '0);
    check("rst_addr", ifc.instr_addr, '0);
    check("rst_parity", ifc.instr_parity_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Program image: random fill, then the test-plan words
    for (int a = 0; a < 2**AW; a++) load_word(a, WS'($urandom));
    load_word(0, 19'h12340);
    load_word(1, 19'h0ABCD);
    load_word(2, 19'h05678);
    load_word(3, 19'h1EFF0);

    // Basic burst: first valid three edges after the start edge, then one word per cycle
    start_burst(0, 4);
    tick();
    check("lat_edge1_valid", ifc.instr_valid, 1'b0);
    tick();
    check("lat_edge2_valid", ifc.instr_valid, 1'b0);
    tick();
    check("lat_edge3_valid", ifc.instr_valid, 1'b1);
    check("first_head_data", ifc.instr_data, 19'h12340);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sustained_valid", ifc.instr_valid, 1'b1);
    end
    wait_done("burst", 1'b0);

    // Consumer stall: head stays put, nothing lost once ready returns
    ifc.instr_ready = 1'b0;
    start_burst(0, 4);
    wait_valid("stall_first_valid");
    for (int i = 0; i < 5; i++) begin
      check("stall_head_data", ifc.instr_data, 19'h12340);
      check("stall_head_addr", ifc.instr_addr, 8'h00);
      tick();
    end
    ifc.instr_ready = 1'b1;
    wait_done("stall", 1'b0);

    // Address wrap
    start_burst(8'hFE, 3);
    wait_done("wrap", 1'b0);

    // Flush one cycle after the third issue, then a one-word burst
    start_burst(0, 4);
    repeat (3) tick();
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    check("flush_valid", ifc.instr_valid, 1'b0);
    check("flush_busy", ifc.busy, 1'b0);
    start_burst(2, 1);
    wait_done("post_flush", 1'b0);

    // Zero-length start is a no-op
    ifc.fetch_start = 1'b1;
    ifc.start_addr  = 8'h05;
    ifc.fetch_len   = '0;
    tick();
    ifc.fetch_start = 1'b0;
    check("zero_len_busy", ifc.busy, 1'b0);
    repeat (4) tick();
    check("zero_len_valid", ifc.instr_valid, 1'b0);

    // Start while busy is ignored
    start_burst(0, 4);
    ifc.fetch_start = 1'b1;
    ifc.start_addr  = 8'h08;
    ifc.fetch_len   = 9'd2;
    tick();
    ifc.fetch_start = 1'b0;
    check("ignored_start_busy", ifc.busy, 1'b1);
    wait_done("ignored_start", 1'b0);

    // Asynchronous reset mid-burst
    start_burst(0, 4);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", ifc.instr_valid, 1'b0);
    check("async_rst_busy", ifc.busy, 1'b0);
    check("async_rst_data", ifc.instr_data, '0);
    check("async_rst_addr", ifc.instr_addr, '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    check("post_rst_valid", ifc.instr_valid, 1'b0);
    check("post_rst_busy", ifc.busy, 1'b0);

`ifdef INSTR_PARITY_EN
    // Corrupt one stored bit of address 1; only that word should flag
    dut.mem[1][0] = ~dut.mem[1][0];
    ref_mem[1]    = ref_mem[1] ^ 19'h1;
    bad[1]        = 1'b1;
    start_burst(0, 4);
    wait_done("parity", 1'b0);
`endif

    // Random bursts with random back-pressure, occasional flush and reloads between bursts
    for (int b = 0; b < 30; b++) begin
      repeat (2) load_word($urandom_range(2**AW - 1), WS'($urandom));
`ifdef INSTR_PARITY_EN
      for (int a = 0; a < 2**AW; a++) bad[a] = 1'b0;
      bad[1] = (ref_mem[1] != 19'h0ABCD ^ 19'h1) ? 1'b0 : 1'b1;
`endif
      ifc.instr_ready = $urandom_range(1);
      start_burst($urandom_range(2**AW - 1), $urandom_range(1, 24));
      if ($urandom_range(5) == 0) begin
        repeat ($urandom_range(1, 6)) begin
          ifc.instr_ready = ($urandom_range(3) != 0);
          tick();
        end
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
      end
      wait_done("rand", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
